carry_lookahead_adder: RTL and testbench

- Parameterised N-bit two's-complement/unsigned adder using carry-lookahead, not ripple, carry generation.
- Computes a + b + cin and presents sum and carry-out through one output register stage.
- Intended as a reusable datapath arithmetic block wherever a fast registered adder is needed.

---
 rtl/carry_lookahead_adder_pkg.sv | 13 +
 rtl/carry_lookahead_adder_cla4_block.sv | 33 +++
 rtl/carry_lookahead_adder.sv | 79 +++++++
 tb/tb_carry_lookahead_adder.sv | 119 +++++++++++
 4 files changed

// File: rtl/carry_lookahead_adder_pkg.sv
// Shared constants and the parameter-legality check for the carry-lookahead adder.
package carry_lookahead_adder_pkg;

  localparam int GROUP_W        = 4;
  localparam int GROUPS_PER_RUN = 4;
  localparam int N_MIN          = 4;
  localparam int N_MAX          = 64;

  function automatic bit n_is_legal(input int n);
    return (n >= N_MIN) && (n <= N_MAX) && ((n % GROUP_W) == 0);
  endfunction

endpackage

// File: rtl/carry_lookahead_adder_cla4_block.sv
// 4-bit carry-lookahead group: fully expanded internal carries plus group generate/propagate.
module cla4_block
  import carry_lookahead_adder_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               gg,
  output logic               gp
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a two-level sum of products of g, p and cin only.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

  assign sum = p ^ c;

endmodule

// File: rtl/carry_lookahead_adder.sv
// Registered N-bit adder: cla4 groups, flattened group-carry lookahead per run of four groups.
module carry_lookahead_adder
  import carry_lookahead_adder_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int NG = N / GROUP_W;
  localparam int NR = (NG + GROUPS_PER_RUN - 1) / GROUPS_PER_RUN;

  if (!n_is_legal(N)) begin : g_illegal_n
    $error("carry_lookahead_adder: N must be a multiple of 4 in 4..64");
  end

  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG:0]   gc;
  logic [N-1:0]  sum_c;

  for (genvar k = 0; k < NG; k++) begin : g_group
    cla4_block u_cla4 (
      .a   (a[k*GROUP_W +: GROUP_W]),
      .b   (b[k*GROUP_W +: GROUP_W]),
      .cin (gc[k]),
      .sum (sum_c[k*GROUP_W +: GROUP_W]),
      .gg  (gg[k]),
      .gp  (gp[k])
    );
  end

  // Within a run, each group carry is an independent sum of products of GG/GP and the
  // run's carry-in; only the run carry-ins chain from one run to the next.
  always_comb begin
    logic acc;
    logic prod;
    gc    = '0;
    acc   = 1'b0;
    prod  = 1'b0;
    gc[0] = cin;
    for (int r = 0; r < NR; r++) begin
      for (int j = 0; j < GROUPS_PER_RUN; j++) begin
        if (r*GROUPS_PER_RUN + j < NG) begin
          prod = gc[r*GROUPS_PER_RUN];
          for (int l = 0; l <= j; l++) begin
            prod = prod & gp[r*GROUPS_PER_RUN + l];
          end
          acc = prod;
          for (int m = 0; m <= j; m++) begin
            prod = gg[r*GROUPS_PER_RUN + m];
            for (int l = m + 1; l <= j; l++) begin
              prod = prod & gp[r*GROUPS_PER_RUN + l];
            end
            acc = acc | prod;
          end
          gc[r*GROUPS_PER_RUN + j + 1] = acc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_c;
      cout <= gc[NG];
    end
  end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Directed and random checks of the registered carry-lookahead adder at N = 8, 16 and 32.
module tb_carry_lookahead_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, cout8;
  logic [31:0] a32, b32, sum32;
  logic        cin32, cout32;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  carry_lookahead_adder #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .sum(sum16), .cout(cout16));
  carry_lookahead_adder #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8));
  carry_lookahead_adder #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .cin(cin32), .sum(sum32), .cout(cout32));

  task automatic check(input string tag, input logic [32:0] observed, input logic [32:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive a 16-bit vector away from the edge, then check one edge later.
  task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic cv, input logic [16:0] expected);
    @(negedge clk);
    a16 = av; b16 = bv; cin16 = cv;
    @(posedge clk);
    #1;
    check(tag, {16'b0, cout16, sum16}, {16'b0, expected});
  endtask

  initial begin
    logic [8:0]  e8;
    logic [16:0] e16;
    logic [32:0] e32;

    rst_n = 1'b0;
    a16 = 16'd10; b16 = 16'd5; cin16 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a32 = '0; b32 = '0; cin32 = 1'b0;
    #2;
    check("reset_initial", {16'b0, cout16, sum16}, 33'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_initial", {16'b0, cout16, sum16}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_first_edge", {16'b0, cout16, sum16}, 33'd15);

    op16("add_10_5",        16'd10,    16'd5,     1'b0, 17'd15);
    op16("group_cross_255", 16'd255,   16'd1,     1'b0, 17'd256);
    op16("add_32766_1",     16'd32766, 16'd1,     1'b0, 17'd32767);
    op16("add_32767_1",     16'd32767, 16'd1,     1'b0, 17'h08000);
    op16("ones_plus_ones",  16'hFFFF,  16'hFFFF,  1'b0, 17'h1FFFE);
    op16("ones_plus_cin",   16'hFFFF,  16'h0000,  1'b1, 17'h10000);
    op16("zero_plus_cin",   16'h0000,  16'h0000,  1'b1, 17'd1);
    op16("zero_zero",       16'h0000,  16'h0000,  1'b0, 17'd0);
    op16("alt_pattern",     16'hAAAA,  16'h5555,  1'b1, 17'h10000);
    op16("mixed_carry",     16'h1234,  16'hF0F0,  1'b1, 17'h10325);

    // Mid-stream asynchronous reset with a carry-out result being presented.
    op16("pre_reset_value", 16'hFFFF,  16'hFFFF,  1'b0, 17'h1FFFE);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_now", {16'b0, cout16, sum16}, 33'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held_low", {16'b0, cout16, sum16}, 33'd0);
    check("reset_held_low_n8", {24'b0, cout8, sum8}, 33'd0);
    check("reset_held_low_n32", {cout32, sum32}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_loads", {16'b0, cout16, sum16}, 33'h1FFFE);

    // Width-specific corners on the other instances.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0;
    a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1;
    @(posedge clk);
    #1;
    check("n8_ones_plus_ones", {24'b0, cout8, sum8}, 33'h1FE);
    check("n32_ones_plus_cin", {cout32, sum32}, 33'h1_0000_0000);

    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      a32 = $urandom;      b32 = $urandom;      cin32 = 1'($urandom);
      e8  = {1'b0, a8}  + {1'b0, b8}  + {8'b0, cin8};
      e16 = {1'b0, a16} + {1'b0, b16} + {16'b0, cin16};
      e32 = {1'b0, a32} + {1'b0, b32} + {32'b0, cin32};
      @(posedge clk);
      #1;
      check("rand_n8",  {24'b0, cout8, sum8},   {24'b0, e8});
      check("rand_n16", {16'b0, cout16, sum16}, {16'b0, e16});
      check("rand_n32", {cout32, sum32}, e32);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
